// File: rtl/hilo_div_ctrl_pkg.sv
// Shared definitions for the EX-stage divide/HI-LO controller.
// State encodings, reset defaults and common constants.
package hilo_div_ctrl_pkg;

    localparam logic        True  = 1'b1;
    localparam logic        False = 1'b0;

    localparam logic [31:0] ZeroWord  = 32'h0000_0000;
    localparam logic [63:0] ZeroDWord = 64'h0;

    localparam logic [31:0] HILO_RST_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/hilo_div_ctrl.sv
// EX-stage sequencer for the multi-cycle divider.
// Owns HI/LO and commits results once the instruction leaves EX.
module hilo_div_ctrl
    import hilo_div_ctrl_pkg::*;
#(
    parameter logic [31:0] HILO_RST_VAL = HILO_RST_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_div,
    input  logic        ex_divu,
    input  logic        ex_mthi,
    input  logic        ex_mtlo,
    input  logic [31:0] ex_opr1,
    input  logic [31:0] ex_opr2,
    input  logic        flush,
    input  logic        stall_in,
    output logic        stall_req,
    output logic        div_start,
    output logic        div_signed,
    output logic        div_abandon,
    output logic [31:0] div_opr1,
    output logic [31:0] div_opr2,
    input  logic        div_ready,
    input  logic [63:0] div_res,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    div_state_e  state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [63:0] res_q, res_d;
    logic        sgn_q, sgn_d;
    logic [31:0] opr1_q, opr1_d;
    logic [31:0] opr2_q, opr2_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            hi_q    <= HILO_RST_VAL;
            lo_q    <= HILO_RST_VAL;
            res_q   <= ZeroDWord;
            sgn_q   <= False;
            opr1_q  <= ZeroWord;
            opr2_q  <= ZeroWord;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            res_q   <= res_d;
            sgn_q   <= sgn_d;
            opr1_q  <= opr1_d;
            opr2_q  <= opr2_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        res_d       = res_q;
        sgn_d       = sgn_q;
        opr1_d      = opr1_q;
        opr2_d      = opr2_q;
        stall_req   = False;
        div_start   = False;
        div_signed  = False;
        div_abandon = False;
        unique case (state_q)
            S_IDLE: begin
                if ((ex_div | ex_divu) && !flush) begin
                    opr1_d    = ex_opr1;
                    opr2_d    = ex_opr2;
                    sgn_d     = ex_div;
                    stall_req = True;
                    state_d   = S_BUSY;
                end
                if (!stall_in && !flush) begin
                    if (ex_mthi) hi_d = ex_opr1;
                    if (ex_mtlo) lo_d = ex_opr1;
                end
            end
            S_BUSY: begin
                div_start  = True;
                div_signed = sgn_q;
                stall_req  = True;
                // Flush beats a same-cycle ready: the result is dropped.
                if (flush) begin
                    div_abandon = True;
                    state_d     = S_IDLE;
                end else if (div_ready) begin
                    res_d   = div_res;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (!stall_in) begin
                    hi_d    = res_q[63:32];
                    lo_d    = res_q[31:0];
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign div_opr1 = opr1_q;
    assign div_opr2 = opr2_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Directed bench for hilo_div_ctrl; the bench plays the divider.
// Results are hand-computed quotient/remainder pairs.
module tb_hilo_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_div, ex_divu, ex_mthi, ex_mtlo;
    logic [31:0] ex_opr1, ex_opr2;
    logic        flush, stall_in;
    logic        stall_req, div_start, div_signed, div_abandon;
    logic [31:0] div_opr1, div_opr2;
    logic        div_ready;
    logic [63:0] div_res;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_hi, exp_lo;

    always #5 clk = ~clk;

    hilo_div_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .ex_div     (ex_div),
        .ex_divu    (ex_divu),
        .ex_mthi    (ex_mthi),
        .ex_mtlo    (ex_mtlo),
        .ex_opr1    (ex_opr1),
        .ex_opr2    (ex_opr2),
        .flush      (flush),
        .stall_in   (stall_in),
        .stall_req  (stall_req),
        .div_start  (div_start),
        .div_signed (div_signed),
        .div_abandon(div_abandon),
        .div_opr1   (div_opr1),
        .div_opr2   (div_opr2),
        .div_ready  (div_ready),
        .div_res    (div_res),
        .hi         (hi),
        .lo         (lo)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clr_ex();
        ex_div  = 1'b0;
        ex_divu = 1'b0;
        ex_mthi = 1'b0;
        ex_mtlo = 1'b0;
        ex_opr1 = '0;
        ex_opr2 = '0;
    endtask

    // mode 0: plain, 1: flush+ready in BUSY, 2: stall 3 in DONE,
    // 3: flush in DONE
    task automatic run_div(input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] res,
                           input int lat, input int mode);
        ex_div  = sgn;
        ex_divu = ~sgn;
        ex_opr1 = a;
        ex_opr2 = b;
        #1 chk("stall_idle", stall_req, 1);
        @(negedge clk);
        for (int i = 0; i < lat; i++) begin
            chk("start_busy", div_start, 1);
            chk("signed_busy", div_signed, sgn);
            chk("opr1_busy", div_opr1, a);
            chk("opr2_busy", div_opr2, b);
            chk("stall_busy", stall_req, 1);
            if (i == lat - 1) begin
                div_ready = 1'b1;
                div_res   = res;
                if (mode == 1) flush = 1'b1;
            end
            #1 chk("abandon_busy", div_abandon, (mode == 1 && i == lat - 1));
            @(negedge clk);
        end
        div_ready = 1'b0;
        div_res   = '0;
        if (mode == 1) begin
            flush = 1'b0;
            clr_ex();
            #1;
            chk("abandon_after", div_abandon, 0);
            chk("start_after_fl", div_start, 0);
            chk("stall_after_fl", stall_req, 0);
            chk("hi_after_fl", hi, exp_hi);
            chk("lo_after_fl", lo, exp_lo);
            return;
        end
        chk("stall_done", stall_req, 0);
        chk("start_done", div_start, 0);
        if (mode == 3) begin
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            clr_ex();
            chk("hi_done_fl", hi, exp_hi);
            chk("lo_done_fl", lo, exp_lo);
            chk("start_done_fl", div_start, 0);
            return;
        end
        if (mode == 2) begin
            stall_in = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk("hi_done_st", hi, exp_hi);
                chk("lo_done_st", lo, exp_lo);
                chk("stall_done_st", stall_req, 0);
            end
            stall_in = 1'b0;
        end
        clr_ex();
        @(negedge clk);
        exp_hi = res[63:32];
        exp_lo = res[31:0];
        chk("hi_commit", hi, exp_hi);
        chk("lo_commit", lo, exp_lo);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        clr_ex();
        flush     = 1'b0;
        stall_in  = 1'b0;
        div_ready = 1'b0;
        div_res   = '0;
        rst       = 1'b1;
        exp_hi    = 32'h0;
        exp_lo    = 32'h0;
        #1;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_start", div_start, 0);
        chk("rst_abandon", div_abandon, 0);
        chk("rst_signed", div_signed, 0);
        chk("rst_stall", stall_req, 0);
        chk("rst_opr1", div_opr1, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_div(1'b1, 32'd100, 32'd7, {32'd2, 32'd14}, 4, 0);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2,
                {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 3, 0);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd16,
                {32'h0000_000F, 32'h0FFF_FFFF}, 5, 0);
        run_div(1'b0, 32'd55, 32'd0, 64'h0, 2, 0);
        run_div(1'b1, 32'd9, 32'd2, {32'd1, 32'd4}, 3, 0);
        run_div(1'b1, 32'd50, 32'd5, {32'd0, 32'd10}, 3, 1);
        run_div(1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 1, 1);
        run_div(1'b1, 32'd20, 32'd3, {32'd2, 32'd6}, 2, 0);
        run_div(1'b0, 32'd30, 32'd4, {32'd2, 32'd7}, 2, 2);
        run_div(1'b0, 32'd99, 32'd10, {32'd9, 32'd9}, 2, 3);

        ex_mthi  = 1'b1;
        ex_opr1  = 32'hDEAD_BEEF;
        stall_in = 1'b1;
        #1 chk("mthi_nostall", stall_req, 0);
        @(negedge clk);
        chk("mthi_held", hi, exp_hi);
        stall_in = 1'b0;
        @(negedge clk);
        clr_ex();
        exp_hi = 32'hDEAD_BEEF;
        chk("mthi_write", hi, exp_hi);

        ex_mtlo = 1'b1;
        ex_opr1 = 32'h1234_5678;
        flush   = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        clr_ex();
        chk("mtlo_flush", lo, exp_lo);

        ex_mtlo = 1'b1;
        ex_opr1 = 32'hCAFE_F00D;
        @(negedge clk);
        clr_ex();
        exp_lo = 32'hCAFE_F00D;
        chk("mtlo_write", lo, exp_lo);

        ex_div  = 1'b1;
        ex_opr1 = 32'd77;
        ex_opr2 = 32'd3;
        @(negedge clk);
        chk("pre_rst_start", div_start, 1);
        clr_ex();
        rst = 1'b1;
        #1;
        chk("mid_rst_hi", hi, 0);
        chk("mid_rst_lo", lo, 0);
        chk("mid_rst_start", div_start, 0);
        chk("mid_rst_signed", div_signed, 0);
        chk("mid_rst_stall", stall_req, 0);
        chk("mid_rst_opr1", div_opr1, 0);
        chk("mid_rst_opr2", div_opr2, 0);
        @(negedge clk);
        rst    = 1'b0;
        exp_hi = 32'h0;
        exp_lo = 32'h0;
        @(negedge clk);
        chk("post_rst_start", div_start, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
